// File: rtl/d_cache_ctrl_if.sv
// CPU- and memory-side bus of the direct-mapped data cache controller.
// The slave modport is the cache controller; the master modport is the CPU plus memory.
interface d_cache_ctrl_if;
    logic [15:0] d_addr;
    logic        re;
    logic        we;
    logic [15:0] wrt_data;
    logic [15:0] d_rd_data;
    logic        d_rdy;
    logic [13:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        m_rdy;

    modport slave (
        input  d_addr, re, we, wrt_data, m_rdata, m_rdy,
        output d_rd_data, d_rdy, m_addr, m_re, m_we, m_wdata
    );

    modport master (
        output d_addr, re, we, wrt_data, m_rdata, m_rdy,
        input  d_rd_data, d_rdy, m_addr, m_re, m_we, m_wdata
    );
endinterface

// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller; lines are 4 x 16-bit words.
// Defining DCACHE_STATS_EN adds saturating hit_cnt / miss_cnt output counters.
module d_cache_ctrl #(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef DCACHE_STATS_EN
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt,
`endif
    d_cache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 14 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e               state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 m_re_q;
    logic                 m_we_q;
    logic [13:0]          m_addr_q;
    logic [63:0]          m_wdata_q;
    logic [3:0][15:0]     data_q [NUM_LINES];
    logic [TAG_W-1:0]     tags_q [NUM_LINES];

    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             req, idle, hit, wr_hit, rd_hit, miss, fill;

    assign off = bus.d_addr[1:0];
    assign idx = bus.d_addr[2 +: IDX_W];
    assign tag = bus.d_addr[15 -: TAG_W];

    // Lookups are only honoured in IDLE; the held request is ignored during a refill.
    assign req    = bus.re | bus.we;
    assign idle   = (state_q == IDLE);
    assign hit    = req && valid_q[idx] && (tags_q[idx] == tag);
    assign wr_hit = idle && hit && bus.we;
    assign rd_hit = idle && hit && !bus.we;
    assign miss   = idle && req && !hit;
    assign fill   = (state_q == ALLOCATE) && bus.m_rdy;

    assign bus.d_rd_data = rd_hit ? data_q[idx][off] : 16'h0000;
    assign bus.d_rdy     = !rst_n || (idle && !miss);
    assign bus.m_re      = m_re_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;

    // NOTE: the data and tag arrays have no reset; a line's valid bit alone says whether they mean anything.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[idx_q] <= bus.m_rdata;
            tags_q[idx_q] <= tag_q;
        end else if (wr_hit) begin
            data_q[idx][off] <= bus.wrt_data;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`endif

    // NOTE: every register here uses <= so all updates see the pre-edge state of the whole block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            idx_q     <= '0;
            tag_q     <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
`ifdef DCACHE_STATS_EN
            hit_q     <= '0;
            miss_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wr_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                    if (miss) begin
                        idx_q <= idx;
                        tag_q <= tag;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q   <= WRITEBACK;
                            m_we_q    <= 1'b1;
                            m_addr_q  <= {tags_q[idx], idx};
                            m_wdata_q <= data_q[idx];
                        end else begin
                            state_q  <= ALLOCATE;
                            m_re_q   <= 1'b1;
                            m_addr_q <= {tag, idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.m_rdy) begin
                        state_q        <= ALLOCATE;
                        dirty_q[idx_q] <= 1'b0;
                        m_we_q         <= 1'b0;
                        m_re_q         <= 1'b1;
                        m_addr_q       <= {tag_q, idx_q};
                    end
                end
                ALLOCATE: begin
                    if (bus.m_rdy) begin
                        state_q        <= IDLE;
                        valid_q[idx_q] <= 1'b1;
                        dirty_q[idx_q] <= 1'b0;
                        m_re_q         <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef DCACHE_STATS_EN
            if ((rd_hit || wr_hit) && (hit_q != 16'hFFFF)) begin
                hit_q <= hit_q + 16'd1;
            end
            if (miss && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_d_cache_ctrl.sv
// Self-checking bench for d_cache_ctrl: table-driven CPU accesses against a latency-controlled memory model.
// Define DCACHE_STATS_EN on both RTL and bench to also check the statistics counters.
module tb_d_cache_ctrl;
    typedef struct {
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          lat;
        bit          exp_miss;
        bit          exp_wb;
        bit          wiggle;
        logic [13:0] wb_addr;
        logic [63:0] wb_data;
    } vec_t;

    typedef struct {
        bit          w;
        logic [13:0] addr;
        logic [63:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    d_cache_ctrl_if bus ();

    d_cache_ctrl #(.NUM_LINES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef DCACHE_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    int excl_viol = 0;
    int rdy_viol = 0;
    int stab_viol = 0;
    logic [63:0] mem [16384];
    txn_t mem_log [$];
    vec_t exp_q [$];
    vec_t vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers each request after mem_lat cycles and logs every transaction.
    initial begin
        logic [13:0] prev_addr;
        logic [63:0] prev_wdata;
        logic        prev_we;
        bus.m_rdy   = 1'b0;
        bus.m_rdata = '0;
        prev_addr   = '0;
        prev_wdata  = '0;
        prev_we     = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_rdy = 1'b0;
            if (bus.m_re && bus.m_we) excl_viol++;
            if ((bus.m_re || bus.m_we) && bus.d_rdy) rdy_viol++;
            if (bus.m_re || bus.m_we) begin
                if (mem_cnt > 0 && (bus.m_addr !== prev_addr || bus.m_we !== prev_we ||
                                    (bus.m_we && bus.m_wdata !== prev_wdata))) stab_viol++;
                prev_addr  = bus.m_addr;
                prev_we    = bus.m_we;
                prev_wdata = bus.m_wdata;
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    bus.m_rdy = 1'b1;
                    if (bus.m_we) begin
                        mem[bus.m_addr] = bus.m_wdata;
                        mem_log.push_back('{1'b1, bus.m_addr, bus.m_wdata});
                    end else begin
                        bus.m_rdata = mem[bus.m_addr];
                        mem_log.push_back('{1'b0, bus.m_addr, 64'h0});
                    end
                    mem_cnt = 0;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    function automatic vec_t mk(input logic re, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp_rdata,
                                input int lat, input bit exp_miss, input bit exp_wb,
                                input logic [13:0] wb_addr, input logic [63:0] wb_data,
                                input bit wiggle);
        vec_t v;
        v.re = re; v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
        v.lat = lat; v.exp_miss = exp_miss; v.exp_wb = exp_wb;
        v.wb_addr = wb_addr; v.wb_data = wb_data; v.wiggle = wiggle;
        return v;
    endfunction

    task automatic do_access(input vec_t v);
        vec_t e;
        txn_t t;
        int   waits;
        int   exp_n;
        int   exp_wait;
        mem_lat = v.lat;
        bus.re = v.re;
        bus.we = v.we;
        bus.d_addr = v.addr;
        bus.wrt_data = v.wdata;
        exp_q.push_back(v);
        #1;
        waits = 0;
        while (!bus.d_rdy && waits < 50) begin
            @(negedge clk);
            if (v.wiggle && waits == 0) begin
                bus.d_addr = ~v.addr;
                bus.wrt_data = ~v.wdata;
                bus.we = ~v.we;
            end else begin
                bus.d_addr = v.addr;
                bus.wrt_data = v.wdata;
                bus.we = v.we;
            end
            #1;
            waits++;
        end
        e = exp_q.pop_front();
        exp_wait = e.exp_miss ? (e.exp_wb ? 2 * e.lat + 1 : e.lat + 1) : 0;
        check("d_rdy", {63'h0, bus.d_rdy}, 64'h1);
        check("rd_data", {48'h0, bus.d_rd_data}, {48'h0, e.exp_rdata});
        check("latency", 64'(waits), 64'(exp_wait));
        check("mem_idle", {62'h0, bus.m_re, bus.m_we}, 64'h0);
        exp_n = e.exp_miss ? (e.exp_wb ? 2 : 1) : 0;
        check("mem_txns", 64'(mem_log.size()), 64'(exp_n));
        if (mem_log.size() == exp_n && e.exp_miss) begin
            if (e.exp_wb) begin
                t = mem_log.pop_front();
                check("wb_is_write", {63'h0, t.w}, 64'h1);
                check("wb_addr", {50'h0, t.addr}, {50'h0, e.wb_addr});
                check("wb_data", t.data, e.wb_data);
            end
            t = mem_log.pop_front();
            check("fill_is_read", {63'h0, t.w}, 64'h0);
            check("fill_addr", {50'h0, t.addr}, {50'h0, e.addr[15:2]});
        end
        mem_log.delete();
        @(posedge clk);
        @(negedge clk);
        bus.re = 1'b0;
        bus.we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = {16'(i * 4 + 3), 16'(i * 4 + 2), 16'(i * 4 + 1), 16'(i * 4)};
        end
        mem[9] = 64'h4444_3333_2222_1111;

        //       re    we    addr      wdata     rdata     lat miss wb  wb_addr   wb_data                 wiggle
        vecs.push_back(mk(1'b1, 1'b0, 16'h0024, 16'h0000, 16'h1111, 3, 1, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0026, 16'h0000, 16'h3333, 1, 0, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0025, 16'hBEEF, 16'h0000, 1, 0, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h00A4, 16'h0000, 16'h00A4, 2, 1, 1, 14'h0009, 64'h4444_3333_BEEF_1111, 1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0025, 16'h0000, 16'hBEEF, 1, 1, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b1, 16'h0024, 16'h00AA, 16'h0000, 1, 0, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0024, 16'h0000, 16'h00AA, 1, 0, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0027, 16'h0000, 16'h4444, 1, 0, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0102, 16'h1234, 16'h0000, 2, 1, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0102, 16'h0000, 16'h1234, 1, 0, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0103, 16'h0000, 16'h0103, 1, 0, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0002, 1, 1, 1, 14'h0040, 64'h0103_1234_0101_0100, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h001F, 16'h0000, 16'h001F, 3, 1, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 1, 0, 14'h0000, 64'h0, 0));
        // Accesses after the mid-ALLOCATE reset: everything misses, and the dirty line was dropped.
        vecs.push_back(mk(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0040, 1, 1, 0, 14'h0000, 64'h0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0024, 16'h0000, 16'h1111, 2, 1, 0, 14'h0000, 64'h0, 0));

        bus.re = 1'b1;
        bus.we = 1'b0;
        bus.d_addr = 16'h0024;
        bus.wrt_data = 16'h0000;
        #22;
        check("rst_d_rdy", {63'h0, bus.d_rdy}, 64'h1);
        check("rst_m_re", {63'h0, bus.m_re}, 64'h0);
        check("rst_m_we", {63'h0, bus.m_we}, 64'h0);
        check("rst_rd_data", {48'h0, bus.d_rd_data}, 64'h0);
        check("rst_m_addr", {50'h0, bus.m_addr}, 64'h0);
        check("rst_m_wdata", bus.m_wdata, 64'h0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", {48'h0, hit_cnt}, 64'h0);
        check("rst_miss_cnt", {48'h0, miss_cnt}, 64'h0);
`endif
        @(negedge clk);
        bus.re = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_d_rdy", {63'h0, bus.d_rdy}, 64'h1);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            do_access(vecs[i]);
`ifdef DCACHE_STATS_EN
            if (i == 1) begin
                check("miss_cnt", {48'h0, miss_cnt}, 64'h1);
                check("hit_cnt", {48'h0, hit_cnt}, 64'h2);
            end
`endif
        end

        // Reset asserted two cycles into an ALLOCATE that memory never answers.
        mem_lat = 20;
        bus.re = 1'b1;
        bus.d_addr = 16'h0040;
        @(negedge clk);
        #1;
        check("alloc_m_re", {63'h0, bus.m_re}, 64'h1);
        check("alloc_m_addr", {50'h0, bus.m_addr}, 64'h10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_re", {63'h0, bus.m_re}, 64'h0);
        check("mid_rst_d_rdy", {63'h0, bus.d_rdy}, 64'h1);
        check("mid_rst_m_addr", {50'h0, bus.m_addr}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.re = 1'b0;
        mem_log.delete();
        @(negedge clk);

        for (int i = 14; i < 16; i++) begin
            do_access(vecs[i]);
        end

        check("m_re_m_we_exclusive", 64'(excl_viol), 64'h0);
        check("d_rdy_low_in_mem_txn", 64'(rdy_viol), 64'h0);
        check("mem_req_stable", 64'(stab_viol), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
